reg_ring_master: RTL and testbench
==================================

Name: reg_ring_master

Overview:
- Initiator end of the UDP register ring.
- Accepts single register transactions from a simple core-side request port and launches each one onto the ring as a one-cycle request.
- Waits for the transaction to return after passing through every responder (generic_regs-based blocks such as the table-flush timer).
- Reports completion, no-ack error or timeout to the requester. One transaction is outstanding at a time.

Parameters:
- UDP_REG_SRC_WIDTH, 2, width of the ring source tag.
- SRC_ID, 0, tag value this master stamps on its requests and matches on return.
- TIMEOUT, 1023, cycles in WAIT before the transaction is abandoned (≥ 2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  request strobe; sampled only in IDLE.
- core_rd_wr_L  in  1  1 = read, 0 = write.
- core_addr  in  `UDP_REG_ADDR_WIDTH  register address.
- core_wdata  in  `CPCI_NF2_DATA_WIDTH  write data.
- core_busy  out  1  high from acceptance until completion pulse.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  valid with core_done; returned unacked.
- core_timeout  out  1  valid with core_done; no return within TIMEOUT.
- core_rdata  out  `CPCI_NF2_DATA_WIDTH  valid with core_done.
- stray_count  out  8  saturating count of discarded ring returns.
- reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  ring launch.
- reg_addr_out  out  `UDP_REG_ADDR_WIDTH  ring launch.
- reg_data_out  out  `CPCI_NF2_DATA_WIDTH  ring launch.
- reg_src_out  out  UDP_REG_SRC_WIDTH  ring launch.
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  ring return.
- reg_addr_in  in  `UDP_REG_ADDR_WIDTH  ring return.
- reg_data_in  in  `CPCI_NF2_DATA_WIDTH  ring return.
- reg_src_in  in  UDP_REG_SRC_WIDTH  ring return.

Behaviour:
- Reset values:
  - All outputs 0, except reg_rd_wr_L_out = 1.
  - State IDLE, timer 0, stray_count 0.
  - Reset mid-transaction abandons the transaction with no core_done.
- State ISSUE is entered on core_req in IDLE.
  - Latch rd_wr_L, addr and wdata on acceptance.
  - core_busy = 1 from the next cycle.
- ISSUE lasts exactly one cycle and drives the ring outputs (all registered):
  - reg_req_out = 1, reg_ack_out = 0, reg_src_out = SRC_ID.
  - Latched rd_wr_L and addr.
  - reg_data_out = wdata for writes, 0 for reads.
- Ring launch latency: core_req at cycle 0 → reg_req_out at cycle 1.
- Ring outputs outside ISSUE: req 0, ack 0, addr 0, data 0, src 0, rd_wr_L 1.
- ISSUE → WAIT. The timer clears on WAIT entry and increments each WAIT cycle.
- Return match: reg_req_in = 1, reg_src_in == SRC_ID and reg_addr_in == latched addr.
- On a match in WAIT, go to DONE.
  - Acked: core_rdata = reg_data_in, core_err = 0.
  - Not acked: core_rdata = 32'hDEAD_BEEF, core_err = 1.
- Timeout: timer == TIMEOUT-1 with no match → DONE with core_timeout = 1, core_rdata = 32'hDEAD_BEEF.
  - A match in that same cycle wins over the timeout.
- DONE lasts one cycle:
  - core_done = 1; core_busy falls in the same cycle.
  - Return to IDLE.
  - Result outputs hold until the next core_done.
  - Return at cycle N → core_done at N+1.
- core_req while busy is ignored; no queueing.
  - core_req in the DONE cycle is ignored.
  - Acceptance resumes in IDLE.
- Stray returns increment stray_count, saturating at 255:
  - any reg_req_in = 1 outside WAIT (late returns after timeout, post-reset leftovers);
  - any reg_req_in = 1 in WAIT that does not match.
- Back-to-back: minimum 4 cycles per transaction (accept, ISSUE, ≥1 WAIT, DONE).

Decomposition:
- Shared register package: state encodings (IDLE/ISSUE/WAIT/DONE), the 32'hDEAD_BEEF error constant, and SRC_ID allocations per master.
- Timer width = log2(TIMEOUT) via the existing LOG2 function macro.
- No sub-module: the FSM and timer live in one module.

Test Plan:
- Read via a single ring responder returning ack with data 32'h0000_0001 two cycles after launch: core_req at cycle 0 (read, addr 0x400000) → reg_req_out at cycle 1 with src = SRC_ID; core_done at cycle 4, core_rdata = 1, core_err = 0.
- Write 32'hCAFE_F00D: reg_data_out = 32'hCAFE_F00D at launch; return acked → core_done with err = 0, timeout = 0.
- Unmapped address, return with ack = 0 → core_err = 1, core_rdata = 32'hDEAD_BEEF.
- TIMEOUT = 16 with no return → core_done exactly 16 WAIT cycles later with timeout = 1. A late return afterwards → stray_count = 1 and no core_done.
- In WAIT, a foreign-src return then the matching return → stray_count increments by 1 and the transaction completes normally. A second core_req while busy is ignored.
- Reset asserted during WAIT → all outputs return to reset values with no core_done. The subsequent return is counted as stray.

Source files
------------

// File: rtl/reg_ring_master_pkg.sv
// Shared definitions for the UDP register ring: width macros, master FSM
// encoding, error read-data pattern and per-master ring source tags.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif

package reg_ring_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } ring_state_t;

  // Read data reported for unacked or abandoned transactions.
  localparam logic [`CPCI_NF2_DATA_WIDTH-1:0] REG_ERR_DATA = 32'hDEAD_BEEF;

  // Ring source tags handed out to the masters sharing the ring.
  localparam int SRC_ID_CPU   = 0;
  localparam int SRC_ID_DMA   = 1;
  localparam int SRC_ID_DEBUG = 2;

endpackage

// File: rtl/reg_ring_master.sv
// Initiator end of the UDP register ring: launches one core transaction at a
// time, waits for it to come back round, and reports data/error/timeout.
module reg_ring_master #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ID            = 0,
  parameter int TIMEOUT           = 1023
) (
  input  logic                              clk,
  input  logic                              reset,

  input  logic                              core_req,
  input  logic                              core_rd_wr_L,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]    core_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   core_wdata,
  output logic                              core_busy,
  output logic                              core_done,
  output logic                              core_err,
  output logic                              core_timeout,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]   core_rdata,
  output logic [7:0]                        stray_count,

  output logic                              reg_req_out,
  output logic                              reg_ack_out,
  output logic                              reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_out,

  input  logic                              reg_req_in,
  input  logic                              reg_ack_in,
  input  logic                              reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_in
);
  import reg_ring_master_pkg::*;

  localparam int TW = `LOG2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG = UDP_REG_SRC_WIDTH'(SRC_ID);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  ring_state_t                      state;
  logic [TW-1:0]                    timer;
  logic [`UDP_REG_ADDR_WIDTH-1:0]   addr_q;
  logic                             match;
  logic                             stray;

  // The returned rd_wr_L bit is informational only; matching is on tag and address.
  logic unused_rd_wr_L_in;
  assign unused_rd_wr_L_in = reg_rd_wr_L_in;

  always_comb begin
    match = reg_req_in && (reg_src_in == SRC_TAG) && (reg_addr_in == addr_q);
    stray = reg_req_in && !((state == ST_WAIT) && match);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      timer           <= '0;
      stray_count     <= 8'd0;
      core_busy       <= 1'b0;
      core_done       <= 1'b0;
      core_err        <= 1'b0;
      core_timeout    <= 1'b0;
      core_rdata      <= '0;
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b1;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      core_done <= 1'b0;
      if (stray)
        stray_count <= sat_inc8(stray_count);

      case (state)
        ST_IDLE: begin
          if (core_req) begin
            // Launch fields are captured straight into the ring registers.
            addr_q          <= core_addr;
            core_busy       <= 1'b1;
            reg_req_out     <= 1'b1;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= core_rd_wr_L;
            reg_addr_out    <= core_addr;
            reg_data_out    <= core_rd_wr_L ? '0 : core_wdata;
            reg_src_out     <= SRC_TAG;
            state           <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          reg_req_out     <= 1'b0;
          reg_ack_out     <= 1'b0;
          reg_rd_wr_L_out <= 1'b1;
          reg_addr_out    <= '0;
          reg_data_out    <= '0;
          reg_src_out     <= '0;
          timer           <= '0;
          state           <= ST_WAIT;
        end

        ST_WAIT: begin
          // A match on the final timer count still completes normally.
          if (match) begin
            core_done    <= 1'b1;
            core_busy    <= 1'b0;
            core_err     <= !reg_ack_in;
            core_timeout <= 1'b0;
            core_rdata   <= reg_ack_in ? reg_data_in : REG_ERR_DATA;
            state        <= ST_DONE;
          end else if (timer == TIMER_LAST) begin
            core_done    <= 1'b1;
            core_busy    <= 1'b0;
            core_err     <= 1'b0;
            core_timeout <= 1'b1;
            core_rdata   <= REG_ERR_DATA;
            state        <= ST_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_ring_master.sv
// Self-checking bench for reg_ring_master: directed table, randomized
// transactions against a transaction-level model, and reset/saturation sequences.
module tb_reg_ring_master;
  localparam int SW      = 2;
  localparam int SRC_ID  = 1;
  localparam int TIMEOUT = 16;
  localparam int AW      = `UDP_REG_ADDR_WIDTH;
  localparam int DW      = `CPCI_NF2_DATA_WIDTH;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset;
  logic core_req, core_rd_wr_L;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic core_busy, core_done, core_err, core_timeout;
  logic [DW-1:0] core_rdata;
  logic [7:0] stray_count;
  logic reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [SW-1:0] reg_src_out;
  logic reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [DW-1:0] reg_data_in;
  logic [SW-1:0] reg_src_in;

  reg_ring_master #(.UDP_REG_SRC_WIDTH(SW), .SRC_ID(SRC_ID), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_rd_wr_L(core_rd_wr_L), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_busy(core_busy), .core_done(core_done),
    .core_err(core_err), .core_timeout(core_timeout), .core_rdata(core_rdata),
    .stray_count(stray_count),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int model_stray = 0;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            d;        // return cycle offset from the launch cycle
    logic          ack;
    logic [31:0]   ret;
    int            fc;       // cycle of a non-matching return, 0 = none
    logic          fc_addr;  // non-matching by address rather than by tag
    logic          spam;     // hold core_req high while busy
    int            exp_e;    // expected core_done cycle
    logic [31:0]   exp_rdata;
    logic          exp_err;
    logic          exp_to;
    int            exp_stray;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ring_idle();
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b1;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  core_busy, 0);
    chk({tag, "_done"},  core_done, 0);
    chk({tag, "_err"},   core_err, 0);
    chk({tag, "_to"},    core_timeout, 0);
    chk({tag, "_rdata"}, core_rdata, 0);
    chk({tag, "_stray"}, stray_count, 0);
    chk({tag, "_ring"}, {reg_req_out, reg_ack_out, reg_rd_wr_L_out, 2'(reg_src_out)}, 5'b00100);
    chk({tag, "_raddr"}, reg_addr_out, 0);
    chk({tag, "_rdat"},  reg_data_out, 0);
  endtask

  function automatic vec_t mkv(logic rw, logic [AW-1:0] addr, logic [31:0] wdata, int d,
                               logic ack, logic [31:0] ret, int fc, logic spam,
                               int e, logic [31:0] rdata, logic err, logic to, int st);
    vec_t v;
    v.rw = rw; v.addr = addr; v.wdata = wdata; v.d = d; v.ack = ack; v.ret = ret;
    v.fc = fc; v.fc_addr = 1'b0; v.spam = spam; v.exp_e = e; v.exp_rdata = rdata;
    v.exp_err = err; v.exp_to = to; v.exp_stray = st;
    return v;
  endfunction

  // Transaction-level model: the return lands inside the wait window only if
  // it arrives 1..TIMEOUT cycles after launch; anything else is stray.
  function automatic vec_t model(vec_t v);
    logic hit;
    hit = (v.d >= 1) && (v.d <= TIMEOUT);
    v.exp_e     = hit ? v.d + 2 : TIMEOUT + 2;
    v.exp_rdata = (hit && v.ack) ? v.ret : ERRD;
    v.exp_err   = hit && !v.ack;
    v.exp_to    = !hit;
    v.exp_stray = (hit ? 0 : 1) + ((v.fc != 0) ? 1 : 0);
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int r, last, launches, done_cnt, done_at, busy_err, idle_err;
    logic [31:0] a_rdata;
    logic a_err, a_to;
    r = 1 + v.d;
    last = ((v.exp_e > r) ? v.exp_e : r) + 2;
    launches = 0; done_cnt = 0; done_at = -1; busy_err = 0; idle_err = 0;
    a_rdata = 'x; a_err = 1'bx; a_to = 1'bx;
    core_req = 1'b1; core_rd_wr_L = v.rw; core_addr = v.addr; core_wdata = v.wdata;
    ring_idle();
    for (int k = 1; k <= last; k++) begin
      tick();
      if (reg_req_out) launches++;
      if (k == 1) begin
        chk({tag, "_launch_rw"},   reg_rd_wr_L_out, v.rw);
        chk({tag, "_launch_addr"}, reg_addr_out, v.addr);
        chk({tag, "_launch_data"}, reg_data_out, v.rw ? 32'd0 : v.wdata);
        chk({tag, "_launch_src"},  {reg_req_out, reg_ack_out, 2'(reg_src_out)}, {2'b10, 2'(SRC_ID)});
      end
      if (k == 2 && (reg_ack_out || !reg_rd_wr_L_out || reg_addr_out != 0 ||
                     reg_data_out != 0 || reg_src_out != 0)) idle_err++;
      if (core_done) begin
        done_cnt++; done_at = k; a_rdata = core_rdata; a_err = core_err; a_to = core_timeout;
      end
      if (core_busy !== (k < v.exp_e)) busy_err++;
      core_req = v.spam && (k <= v.exp_e);
      ring_idle();
      if (k == r) begin
        reg_req_in = 1'b1; reg_ack_in = v.ack; reg_rd_wr_L_in = v.rw;
        reg_addr_in = v.addr; reg_data_in = v.ret; reg_src_in = SW'(SRC_ID);
      end else if (k == v.fc) begin
        reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_data_in = 32'h5555_AAAA;
        reg_addr_in = v.fc_addr ? (v.addr ^ AW'(1)) : v.addr;
        reg_src_in  = v.fc_addr ? SW'(SRC_ID) : SW'(SRC_ID ^ 2);
      end
    end
    model_stray = model_stray + v.exp_stray;
    if (model_stray > 255) model_stray = 255;
    chk({tag, "_launches"}, launches, 1);
    chk({tag, "_ring_idle"}, idle_err, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_at, v.exp_e);
    chk({tag, "_rdata"}, a_rdata, v.exp_rdata);
    chk({tag, "_err_to"}, {a_err, a_to}, {v.exp_err, v.exp_to});
    chk({tag, "_busy"}, busy_err, 0);
    chk({tag, "_stray"}, stray_count, model_stray);
  endtask

  vec_t dir [7];

  initial begin
    int done_seen;
    vec_t v;
    reset = 1'b1;
    core_req = 1'b0; core_rd_wr_L = 1'b1; core_addr = '0; core_wdata = '0;
    ring_idle();
    repeat (3) tick();
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick();

    //         rw    addr          wdata          d   ack   ret            fc spam e   rdata          err   to    stray
    dir[0] = mkv(1'b1, 23'h400000, 32'h0,          2, 1'b1, 32'h0000_0001, 0, 1'b0, 4, 32'h0000_0001, 1'b0, 1'b0, 0);
    dir[1] = mkv(1'b0, 23'h000123, 32'hCAFE_F00D,  3, 1'b1, 32'hCAFE_F00D, 0, 1'b0, 5, 32'hCAFE_F00D, 1'b0, 1'b0, 0);
    dir[2] = mkv(1'b1, 23'h7FFFFF, 32'h0,          1, 1'b0, 32'h1234_5678, 0, 1'b0, 3, 32'hDEAD_BEEF, 1'b1, 1'b0, 0);
    dir[3] = mkv(1'b1, 23'h000040, 32'h0,         20, 1'b1, 32'h0000_0099, 0, 1'b0, 18, 32'hDEAD_BEEF, 1'b0, 1'b1, 1);
    dir[4] = mkv(1'b1, 23'h000044, 32'h0,          5, 1'b1, 32'hABCD_0123, 3, 1'b1, 7, 32'hABCD_0123, 1'b0, 1'b0, 1);
    dir[5] = mkv(1'b0, 23'h000048, 32'h0F0F_0F0F, 16, 1'b1, 32'h0F0F_0F0F, 0, 1'b0, 18, 32'h0F0F_0F0F, 1'b0, 1'b0, 0);
    dir[6] = mkv(1'b1, 23'h00004C, 32'h0,          0, 1'b1, 32'h0000_0007, 0, 1'b0, 18, 32'hDEAD_BEEF, 1'b0, 1'b1, 1);
    for (int i = 0; i < 7; i++) run_txn(dir[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.rw = 1'($urandom_range(0, 1));
      v.addr = AW'($urandom);
      v.wdata = $urandom;
      v.d = $urandom_range(0, TIMEOUT + 4);
      v.ack = 1'($urandom_range(0, 1));
      v.ret = $urandom;
      v.spam = 1'($urandom_range(0, 1));
      v.fc_addr = 1'($urandom_range(0, 1));
      v.fc = 0;
      v = model(v);
      if ($urandom_range(0, 1) == 1) begin
        v.fc = $urandom_range(1, v.exp_e + 1);
        if (v.fc == 1 + v.d) v.fc = 0;
        v = model(v);
      end
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of WAIT abandons the transaction; its return is stray.
    done_seen = 0;
    core_req = 1'b1; core_rd_wr_L = 1'b1; core_addr = 23'h000200; core_wdata = '0;
    tick(); core_req = 1'b0;
    tick();
    tick(); reset = 1'b1;
    tick(); if (core_done) done_seen++;
    tick(); if (core_done) done_seen++;
    chk_reset_outputs("midreset");
    reset = 1'b0;
    model_stray = 0;
    tick(); if (core_done) done_seen++;
    reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_src_in = SW'(SRC_ID);
    reg_addr_in = 23'h000200; reg_data_in = 32'h0000_0042;
    tick(); if (core_done) done_seen++;
    ring_idle();
    tick(); if (core_done) done_seen++;
    model_stray = 1;
    chk("midreset_no_done", done_seen, 0);
    chk("midreset_late_stray", stray_count, model_stray);
    chk("midreset_idle_busy", core_busy, 0);

    // Stray counter saturates.
    reg_req_in = 1'b1; reg_src_in = SW'(SRC_ID ^ 2); reg_addr_in = 23'h000001;
    for (int i = 0; i < 260; i++) begin
      tick();
      if (core_done) done_seen++;
    end
    ring_idle();
    tick();
    model_stray = (model_stray + 260 > 255) ? 255 : model_stray + 260;
    chk("stray_saturate", stray_count, model_stray);
    chk("stray_no_done", done_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
